// File: rtl/free_page_pool_pkg.sv
// Shared types and defaults for the free-page pool: page/count widths and phase encodings.
package free_page_pool_pkg;

    localparam int FPP_PAGE_NUM = 2048;
    localparam int FPP_PAGE_AW  = $clog2(FPP_PAGE_NUM);

    typedef logic [FPP_PAGE_AW-1:0] page_t;
    typedef logic [FPP_PAGE_AW:0]   cnt_t;

    // Pool phase: INIT serves the reset-time counter, RUN serves returned pages.
    localparam logic [0:0] PH_INIT = 1'b0;
    localparam logic [0:0] PH_RUN  = 1'b1;

endpackage

// File: rtl/free_page_pool_if.sv
// Allocation/return bus of the free-page pool; slave = pool, master = enqueue/dequeue client.
interface free_page_pool_if
    import free_page_pool_pkg::*;
#(
    parameter int PAGE_AW = FPP_PAGE_AW
);

    // Handshake: a pop is taken on every edge where alloc_pop & alloc_valid (alloc_page is
    // show-ahead and changes only after a taken pop); a push is taken on every edge where
    // free_push & !pool_full and the page is not already free; there is no other back-pressure.
    // Rejected requests raise the matching err_* as a registered pulse in the following cycle.
    logic               alloc_valid;
    logic [PAGE_AW-1:0] alloc_page;
    logic               alloc_pop;
    logic               free_push;
    logic [PAGE_AW-1:0] free_page;
    logic [PAGE_AW:0]   free_cnt;
    logic               pool_full;
    logic               err_underflow;
    logic               err_overflow;
    logic               err_dfree;
    logic [0:0]         dbg_phase;

    modport slave (
        output alloc_valid, alloc_page, free_cnt, pool_full,
        output err_underflow, err_overflow, err_dfree, dbg_phase,
        input  alloc_pop, free_push, free_page
    );

    modport master (
        input  alloc_valid, alloc_page, free_cnt, pool_full,
        input  err_underflow, err_overflow, err_dfree, dbg_phase,
        output alloc_pop, free_push, free_page
    );

endinterface

// File: rtl/fpp_sdp_ram.sv
// Simple dual-port RAM backing the return queue: one write port, one read port with
// a registered (1-cycle) read. Same-address read/write returns the old contents.
module fpp_sdp_ram
    import free_page_pool_pkg::*;
#(
    parameter int DEPTH = FPP_PAGE_NUM,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = AW
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    (* ram_style = "block" *) logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/free_page_pool.sv
// Free-page manager: serves pages 0..PAGE_NUM-1 from a counter after reset, then returned
// pages in FIFO order from a BRAM queue. Optional double-free bitmap: FREE_PAGE_POOL_DFREE_CHK_EN.
module free_page_pool
    import free_page_pool_pkg::*;
#(
    parameter int PAGE_NUM = FPP_PAGE_NUM,
    parameter int PAGE_AW  = $clog2(PAGE_NUM)
) (
    input  logic               clk,
    input  logic               rst_n,
    free_page_pool_if.slave    bus
);

    localparam int              CW         = PAGE_AW + 1;
    localparam logic [CW-1:0]   C_PAGE_NUM = CW'(PAGE_NUM);

    logic [0:0]         r_phase;
    logic [CW-1:0]      r_init_cnt;
    logic [PAGE_AW-1:0] r_head;
    logic               r_head_valid;
    logic               r_pend;
    logic               r_fwd_sel;
    logic [PAGE_AW-1:0] r_fwd_data;
    logic [PAGE_AW-1:0] r_wr_ptr;
    logic [PAGE_AW-1:0] r_rd_ptr;
    logic [CW-1:0]      r_free_cnt;
    logic               r_err_underflow;
    logic               r_err_overflow;
    logic               r_err_dfree;

    logic               w_pop_ok;
    logic               w_push_ok;
    logic               w_full;
    logic               w_dfree;
    logic [CW-1:0]      w_init_rem;
    logic [CW-1:0]      w_q_cnt;
    logic               w_head_free;
    logic               w_head_from_pend;
    logic               w_pend_free;
    logic               w_rd_issue;
    logic               w_rd_fwd;
    logic [PAGE_AW-1:0] w_ram_rdata;
    logic [PAGE_AW-1:0] w_pend_data;

    assign w_full   = (r_free_cnt == C_PAGE_NUM);
    assign w_pop_ok = bus.alloc_pop & r_head_valid;
    assign w_push_ok = bus.free_push & ~w_full & ~w_dfree;

    // Pool = head + pending read + unserved counter pages + entries still waiting in RAM.
    assign w_init_rem = (r_phase == PH_INIT) ? (C_PAGE_NUM - r_init_cnt) : '0;
    assign w_q_cnt    = r_free_cnt - CW'(r_head_valid) - CW'(r_pend) - w_init_rem;

    assign w_head_free      = ~r_head_valid | w_pop_ok;
    assign w_head_from_pend = w_head_free & (r_phase == PH_RUN) & r_pend;
    assign w_pend_free      = ~r_pend | w_head_from_pend;

    // Reading an empty queue means reading the slot written this very edge, so capture the
    // write data instead of the RAM's stale read-first output.
    assign w_rd_issue  = w_pend_free & ((w_q_cnt != '0) | w_push_ok);
    assign w_rd_fwd    = (w_q_cnt == '0);
    assign w_pend_data = r_fwd_sel ? r_fwd_data : w_ram_rdata;

    fpp_sdp_ram #(
        .DEPTH (PAGE_NUM),
        .AW    (PAGE_AW),
        .DW    (PAGE_AW)
    ) u_ram (
        .i_clk   (clk),
        .i_we    (w_push_ok),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.free_page),
        .i_re    (w_rd_issue),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase      <= PH_INIT;
            r_init_cnt   <= CW'(1);
            r_head       <= '0;
            r_head_valid <= 1'b1;
        end else if (w_head_free) begin
            if (r_phase == PH_INIT) begin
                r_head       <= r_init_cnt[PAGE_AW-1:0];
                r_head_valid <= 1'b1;
                r_init_cnt   <= r_init_cnt + CW'(1);
                if (r_init_cnt == C_PAGE_NUM - CW'(1)) begin
                    r_phase <= PH_RUN;
                end
            end else if (r_pend) begin
                r_head       <= w_pend_data;
                r_head_valid <= 1'b1;
            end else begin
                r_head_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend     <= 1'b0;
            r_fwd_sel  <= 1'b0;
            r_fwd_data <= '0;
            r_rd_ptr   <= '0;
        end else if (w_rd_issue) begin
            r_pend     <= 1'b1;
            r_fwd_sel  <= w_rd_fwd;
            r_fwd_data <= bus.free_page;
            r_rd_ptr   <= r_rd_ptr + PAGE_AW'(1);
        end else if (w_head_from_pend) begin
            r_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_free_cnt <= C_PAGE_NUM;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PAGE_AW'(1);
            end
            if (w_push_ok && !w_pop_ok) begin
                r_free_cnt <= r_free_cnt + CW'(1);
            end else if (w_pop_ok && !w_push_ok) begin
                r_free_cnt <= r_free_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_underflow <= 1'b0;
            r_err_overflow  <= 1'b0;
            r_err_dfree     <= 1'b0;
        end else begin
            r_err_underflow <= bus.alloc_pop & ~r_head_valid;
            r_err_overflow  <= bus.free_push & w_full;
            r_err_dfree     <= w_dfree;
        end
    end

`ifdef FREE_PAGE_POOL_DFREE_CHK_EN
    logic [PAGE_NUM-1:0] r_in_pool;

    // A page leaving through the head this same edge is no longer free, so its return is legal.
    assign w_dfree = bus.free_push & ~w_full & r_in_pool[bus.free_page]
                   & ~(w_pop_ok & (r_head == bus.free_page));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_pool <= '1;
        end else begin
            if (w_pop_ok) begin
                r_in_pool[r_head] <= 1'b0;
            end
            if (w_push_ok) begin
                r_in_pool[bus.free_page] <= 1'b1;
            end
        end
    end
`else
    assign w_dfree = 1'b0;
`endif

    assign bus.alloc_valid   = r_head_valid;
    assign bus.alloc_page    = r_head;
    assign bus.free_cnt      = r_free_cnt;
    assign bus.pool_full     = w_full;
    assign bus.err_underflow = r_err_underflow;
    assign bus.err_overflow  = r_err_overflow;
    assign bus.err_dfree     = r_err_dfree;
    assign bus.dbg_phase     = r_phase;

endmodule
